// File: rtl/counter_scheduler_pkg.sv
// rtl/counter_scheduler_pkg.sv - shared types and round-robin pick for counter_scheduler
package counter_sched_pkg;

    localparam int MAXREQ = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } rr_sel_t;

    // Scan last+1, last+2, ... modulo n; the nearest asserted request wins.
    function automatic rr_sel_t rr_pick(input logic [MAXREQ-1:0] req,
                                        input logic [2:0]        last,
                                        input int                n);
        rr_sel_t    sel;
        logic [2:0] cand;
        sel = '0;
        for (int k = MAXREQ; k >= 1; k--) begin
            cand = 3'((int'(last) + k) % n);
            if (k <= n && req[cand]) begin
                sel.valid = 1'b1;
                sel.idx   = cand;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/counter_scheduler_tick_gen.sv
// rtl/counter_scheduler_tick_gen.sv - shared prescaler producing one wrap per PRESCALE enabled cycles
module tick_gen #(
    parameter int PRESCALE = 100,
    parameter int PW       = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic wrap
);

    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt_q;

    // Combinational so the owner FSM can act on the wrap in the same cycle.
    assign wrap = en && (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= wrap ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/counter_scheduler.sv
// rtl/counter_scheduler.sv - round-robin sharing of one prescaled interval counter
module counter_scheduler
    import counter_sched_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int CW       = 16,
    parameter int PRESCALE = 100,
    parameter int PW       = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*CW-1:0] dur,
    input  logic               abort,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic               busy,
    output logic [CW-1:0]      remaining,
    output logic               tick
);

    state_e            state_q;
    logic [NREQ-1:0]   gnt_q;
    logic [NREQ-1:0]   done_q;
    logic              busy_q;
    logic              tick_q;
    logic [CW-1:0]     rem_q;
    logic [2:0]        last_q;
    logic [2:0]        owner_q;

    logic [MAXREQ-1:0] req_ext;
    rr_sel_t           pick;
    logic              grant;
    logic [NREQ-1:0]   pick_oh;
    logic [NREQ-1:0]   owner_oh;
    logic [CW-1:0]     pick_dur;
    logic              wrap;

    assign req_ext  = MAXREQ'(req);
    assign pick     = rr_pick(req_ext, last_q, NREQ);
    assign grant    = (state_q == IDLE) && !abort && pick.valid;
    assign pick_oh  = NREQ'(1) << pick.idx;
    assign owner_oh = NREQ'(1) << owner_q;
    assign pick_dur = dur[int'(pick.idx)*CW +: CW];

    tick_gen #(
        .PRESCALE (PRESCALE),
        .PW       (PW)
    ) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .clear (grant),
        .en    (state_q == RUN),
        .wrap  (wrap)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            tick_q  <= 1'b0;
            rem_q   <= '0;
            last_q  <= 3'(NREQ - 1);
            owner_q <= '0;
        end else begin
            done_q <= '0;
            tick_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        gnt_q   <= pick_oh;
                        rem_q   <= pick_dur;
                        owner_q <= pick.idx;
                    end
                end
                RUN: begin
                    // Cancellation outranks expiry, so a late abort or drop never yields done.
                    if (abort || !req_ext[owner_q]) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        gnt_q   <= '0;
                        rem_q   <= '0;
                        last_q  <= owner_q;
                    end else if (rem_q == '0) begin
                        state_q <= DONE;
                        gnt_q   <= '0;
                        done_q  <= owner_oh;
                    end else if (wrap) begin
                        tick_q <= 1'b1;
                        rem_q  <= rem_q - 1'b1;
                        if (rem_q == CW'(1)) begin
                            state_q <= DONE;
                            gnt_q   <= '0;
                            done_q  <= owner_oh;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    gnt_q   <= '0;
                    rem_q   <= '0;
                    last_q  <= owner_q;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    gnt_q   <= '0;
                    rem_q   <= '0;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign remaining = rem_q;
    assign tick      = tick_q;

endmodule

// File: tb/tb_counter_scheduler.sv
// tb/tb_counter_scheduler.sv - self-checking bench for counter_scheduler
module tb_counter_scheduler;

    localparam int NREQ     = 4;
    localparam int CW       = 16;
    localparam int PRESCALE = 4;
    localparam int PW       = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ*CW-1:0] dur;
    logic               abort;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic               busy;
    logic [CW-1:0]      remaining;
    logic               tick;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: phase 0 idle, 1 counting, 2 done cycle; time kept as elapsed cycles.
    int              m_phase, m_owner, m_last, m_dur, m_el;
    logic [NREQ-1:0] e_gnt, e_done;
    logic            e_busy, e_tick;
    logic [CW-1:0]   e_rem;

    always #5 clk = ~clk;

    counter_scheduler #(
        .NREQ(NREQ), .CW(CW), .PRESCALE(PRESCALE), .PW(PW)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .dur(dur), .abort(abort),
        .gnt(gnt), .done(done), .busy(busy), .remaining(remaining), .tick(tick)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pick_rr(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic int oh2i(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_owner = 0; m_last = NREQ - 1; m_dur = 0; m_el = 0;
        e_gnt = '0; e_done = '0; e_busy = 1'b0; e_tick = 1'b0; e_rem = '0;
    endtask

    task automatic model_step();
        int lim;
        e_done = '0;
        e_tick = 1'b0;
        case (m_phase)
            0: if (!abort && req != '0) begin
                m_owner = pick_rr(req, m_last);
                m_dur   = int'(dur[m_owner*CW +: CW]);
                m_el    = 0;
                m_phase = 1;
                e_gnt   = NREQ'(1) << m_owner;
                e_rem   = CW'(m_dur);
                e_busy  = 1'b1;
            end
            1: begin
                m_el++;
                lim = (m_dur == 0) ? 1 : m_dur * PRESCALE;
                if (abort || !req[m_owner]) begin
                    m_phase = 0; m_last = m_owner;
                    e_gnt = '0; e_rem = '0; e_busy = 1'b0;
                end else if (m_el >= lim) begin
                    m_phase = 2;
                    e_done  = NREQ'(1) << m_owner;
                    e_gnt   = '0;
                    e_rem   = '0;
                    e_tick  = (m_dur != 0);
                end else begin
                    e_rem  = CW'(m_dur - m_el / PRESCALE);
                    e_tick = (m_el % PRESCALE == 0);
                end
            end
            default: begin
                m_phase = 0; m_last = m_owner; e_busy = 1'b0;
            end
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        check_eq("gnt", 32'(gnt), 32'(e_gnt));
        check_eq("done", 32'(done), 32'(e_done));
        check_eq("busy", 32'(busy), 32'(e_busy));
        check_eq("remaining", 32'(remaining), 32'(e_rem));
        check_eq("tick", 32'(tick), 32'(e_tick));
        check_eq("gnt_onehot", 32'($countones(gnt) > 1), 32'd0);
    endtask

    task automatic set_dur(input int i, input int v);
        dur[i*CW +: CW] = CW'(v);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req = '0;
        abort = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, nt, gcyc, found;
        int order[$];
        int exp_order[5];
        logic [NREQ-1:0] pg;

        rst = 1'b0; req = '0; dur = '0; abort = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_eq("rst_gnt", 32'(gnt), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_rem", 32'(remaining), 32'd0);
        check_eq("rst_tick", 32'(tick), 32'd0);
        rst = 1'b1;

        // Single requester, dur=3.
        set_dur(0, 3);
        req = 4'b0001;
        step();
        check_eq("t1_gnt", 32'(gnt), 32'b0001);
        lat = 0; nt = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (tick) nt++;
            if (done[0]) begin lat = k; break; end
        end
        check_eq("t1_done_lat", 32'(lat), 32'd12);
        check_eq("t1_ticks", 32'(nt), 32'd3);
        req = '0;
        step();
        check_eq("t1_busy_low", 32'(busy), 32'd0);
        step();

        // All four requesting with dur=1, held high.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_dur(i, 1);
        req = 4'b1111;
        pg = '0; gcyc = 0;
        for (int k = 0; k < 80 && order.size() < 5; k++) begin
            step();
            if (gnt != '0 && pg == '0) begin order.push_back(oh2i(gnt)); gcyc = cyc; end
            if (done != '0) check_eq("t2_done_lat", 32'(cyc - gcyc), 32'd4);
            pg = gnt;
        end
        exp_order = '{0, 1, 2, 3, 0};
        check_eq("t2_grants", 32'(order.size()), 32'd5);
        for (int i = 0; i < order.size() && i < 5; i++) check_eq("t2_order", 32'(order[i]), 32'(exp_order[i]));
        req = '0;
        step(); step();

        // Zero-length interval.
        do_reset();
        set_dur(2, 0);
        req = 4'b0100;
        step();
        check_eq("t3_gnt", 32'(gnt), 32'b0100);
        check_eq("t3_rem", 32'(remaining), 32'd0);
        step();
        check_eq("t3_done", 32'(done), 32'b0100);
        check_eq("t3_rem2", 32'(remaining), 32'd0);
        req = '0;
        step(); step();

        // Abort five cycles into a run; next grant goes past the aborted owner.
        do_reset();
        set_dur(1, 3); set_dur(2, 2);
        req = 4'b0010;
        step();
        check_eq("t4_gnt", 32'(gnt), 32'b0010);
        for (int k = 0; k < 4; k++) step();
        abort = 1'b1;
        step();
        check_eq("t4_gnt_drop", 32'(gnt), 32'd0);
        check_eq("t4_no_done", 32'(done), 32'd0);
        check_eq("t4_rem", 32'(remaining), 32'd0);
        abort = 1'b0;
        req = 4'b1111;
        step();
        check_eq("t4_next", 32'(gnt), 32'b0100);
        req = '0;
        step(); step();

        // Owner drops request while another waits.
        do_reset();
        set_dur(1, 3); set_dur(3, 2);
        req = 4'b0010;
        step();
        req = 4'b1010;
        for (int k = 0; k < 3; k++) step();
        req = 4'b1000;
        step();
        check_eq("t5_drop_gnt", 32'(gnt), 32'd0);
        check_eq("t5_no_done", 32'(done), 32'd0);
        found = 0;
        for (int k = 0; k < 2 && found == 0; k++) begin
            step();
            if (gnt == 4'b1000) found = 1;
        end
        check_eq("t5_gnt3", 32'(found), 32'd1);
        req = '0;
        step(); step();

        // Maximum duration, then asynchronous reset mid-run.
        do_reset();
        set_dur(2, 0);
        req = 4'b0100;
        step(); step();
        req = '0;
        step();
        set_dur(0, 16'hFFFF);
        req = 4'b0001;
        step();
        check_eq("t6_rem_max", 32'(remaining), 32'hFFFF);
        for (int k = 0; k < 4; k++) step();
        check_eq("t6_rem_dec", 32'(remaining), 32'hFFFE);
        #2;
        rst = 1'b0;
        #1;
        check_eq("t6_async_gnt", 32'(gnt), 32'd0);
        check_eq("t6_async_busy", 32'(busy), 32'd0);
        check_eq("t6_async_rem", 32'(remaining), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        req = 4'b1001;
        step();
        check_eq("t6_prio0", 32'(gnt), 32'b0001);
        req = '0;
        step(); step();

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req[i]) begin
                    if (e_done[i]) begin
                        if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
                    end else if ($urandom_range(59, 0) == 0) begin
                        req[i] = 1'b0;
                    end
                end else if ($urandom_range(3, 0) == 0) begin
                    set_dur(i, int'($urandom_range(3, 0)));
                    req[i] = 1'b1;
                end
            end
            abort = ($urandom_range(29, 0) == 0);
            step();
        end
        req = '0;
        abort = 1'b0;
        step(); step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
